// File: rtl/game_ctrl_if.sv
// Play-state bus between the game controller and the attacker/shooter/VGA side.
// The master side drives start, frame position and hit flags; the controller answers with play controls.
interface game_ctrl_if #(
    parameter int NUM_ATK = 5,
    parameter int SCORE_W = 16
);
    logic                start_btn;
    logic [16:0]         H_count;
    logic [16:0]         V_count;
    logic [NUM_ATK-1:0]  atk_over;
    logic                game_stop;
    logic                game_on;
    logic                game_over_all;
    logic [2:0]          lives;
    logic [SCORE_W-1:0]  score;
    logic [1:0]          state;

    modport master (
        output start_btn, H_count, V_count, atk_over,
        input  game_stop, game_on, game_over_all, lives, score, state
    );

    modport slave (
        input  start_btn, H_count, V_count, atk_over,
        output game_stop, game_on, game_over_all, lives, score, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Play-state controller: sequences IDLE/PLAY/HIT/OVER, counts lives and frames survived,
// and drives the shared game_stop/game_on controls back to the attackers and shooter.
module game_ctrl #(
    parameter int NUM_ATK         = 5,
    parameter int LIVES_INIT      = 3,
    parameter int HIT_HOLD_FRAMES = 60,
    parameter int SCORE_W         = 16
) (
    input  logic        clk_65M,
    input  logic        clear,
    game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        HIT  = 2'b10,
        OVER = 2'b11
    } state_e;

    localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
    localparam logic [7:0] HOLD_LAST = 8'(HIT_HOLD_FRAMES - 1);

    state_e             state_q;
    logic               s1_q, s2_q, s3_q;
    logic [2:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic [7:0]         hold_q;
    logic               stop_q, on_q, over_q;

    logic frame_tick, start_edge, hit;

    assign frame_tick = (bus.V_count == 17'd0) && (bus.H_count == 17'd0);
    assign start_edge = s2_q & ~s3_q;
    // Several attackers flagging in one cycle still cost a single life.
    assign hit        = |bus.atk_over[NUM_ATK-1:0];

    always_ff @(posedge clk_65M) begin
        if (!clear) begin
            state_q <= IDLE;
            stop_q  <= 1'b1;
            on_q    <= 1'b0;
            over_q  <= 1'b0;
            lives_q <= LIVES_RST;
            score_q <= '0;
            hold_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            s1_q <= bus.start_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
            case (state_q)
                IDLE, OVER: begin
                    if (start_edge) begin
                        state_q <= PLAY;
                        stop_q  <= 1'b0;
                        on_q    <= 1'b1;
                        over_q  <= 1'b0;
                        lives_q <= LIVES_RST;
                        score_q <= '0;
                    end
                end
                PLAY: begin
                    if (hit) begin
                        stop_q <= 1'b1;
                        on_q   <= 1'b0;
                        if (lives_q == 3'd1) begin
                            lives_q <= 3'd0;
                            over_q  <= 1'b1;
                            state_q <= OVER;
                        end else begin
                            lives_q <= lives_q - 3'd1;
                            hold_q  <= '0;
                            state_q <= HIT;
                        end
                    end else if (frame_tick && (score_q != '1)) begin
                        score_q <= score_q + SCORE_W'(1);
                    end
                end
                HIT: begin
                    // Attackers are parked under game_stop here, so their flags are ignored.
                    if (frame_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            stop_q  <= 1'b0;
                            on_q    <= 1'b1;
                            state_q <= PLAY;
                        end else begin
                            hold_q <= hold_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    stop_q  <= 1'b1;
                    on_q    <= 1'b0;
                    over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state         = state_q;
    assign bus.game_stop     = stop_q;
    assign bus.game_on       = on_q;
    assign bus.game_over_all = over_q;
    assign bus.lives         = lives_q;
    assign bus.score         = score_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_game_ctrl;
    localparam logic [1:0] S_IDLE = 2'b00, S_PLAY = 2'b01, S_HIT = 2'b10, S_OVER = 2'b11;

    typedef struct {
        string       tag;
        int          cyc;
        logic [1:0]  st;
        logic [2:0]  lives;
        logic [15:0] score;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    game_ctrl_if #(.NUM_ATK(5), .SCORE_W(16)) bus ();

    game_ctrl #(.NUM_ATK(5), .LIVES_INIT(3), .HIT_HOLD_FRAMES(60), .SCORE_W(16)) dut (
        .clk_65M (clk),
        .clear   (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outputs after the edge that ends cycle c; control outputs follow from the state.
    task automatic expect_at(input string tag, input int c, input logic [1:0] st,
                             input logic [2:0] lv, input logic [15:0] sc);
        exp_t e;
        e.tag = tag; e.cyc = c; e.st = st; e.lives = lv; e.score = sc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".state"}, 32'(bus.state),         32'(e.st));
            chk({e.tag, ".stop"},  32'(bus.game_stop),     32'(e.st != S_PLAY));
            chk({e.tag, ".on"},    32'(bus.game_on),       32'(e.st == S_PLAY));
            chk({e.tag, ".over"},  32'(bus.game_over_all), 32'(e.st == S_OVER));
            chk({e.tag, ".lives"}, 32'(bus.lives),         32'(e.lives));
            chk({e.tag, ".score"}, 32'(bus.score),         32'(e.score));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_seq(input string tag, input logic [1:0] from, input logic [2:0] lv,
                             input logic [15:0] sc);
        int c;
        c = cyc;
        bus.start_btn = 1'b1;
        expect_at({tag, ".k"},   c + 1, from, lv, sc);
        expect_at({tag, ".k1"},  c + 2, from, lv, sc);
        expect_at({tag, ".k2"},  c + 3, S_PLAY, 3'd3, 16'd0);
        tick(1);
        bus.start_btn = 1'b0;
        tick(2);
    endtask

    task automatic play_frames(input int n, input logic [2:0] lv, input logic [15:0] sc0);
        int c;
        c = cyc;
        for (int i = 1; i <= n; i++) expect_at("frame", c + i, S_PLAY, lv, sc0 + 16'(i));
        bus.H_count = 17'd0; bus.V_count = 17'd0;
        tick(n);
        bus.H_count = 17'd1;
        expect_at("frame_idle", c + n + 1, S_PLAY, lv, sc0 + 16'(n));
        tick(1);
    endtask

    // Non-fatal hit, flags held through most of the hold, then 60 frames back to PLAY.
    task automatic hit_nf(input logic [4:0] pat, input logic [2:0] lv, input logic [15:0] sc);
        int c;
        c = cyc;
        expect_at("hit.enter", c + 1,  S_HIT,  lv, sc);
        expect_at("hit.mid",   c + 30, S_HIT,  lv, sc);
        expect_at("hit.last",  c + 60, S_HIT,  lv, sc);
        expect_at("hit.exit",  c + 61, S_PLAY, lv, sc);
        expect_at("hit.play",  c + 62, S_PLAY, lv, sc);
        bus.atk_over = pat; bus.H_count = 17'd1;
        tick(1);
        bus.H_count = 17'd0; bus.V_count = 17'd0;
        tick(59);
        bus.atk_over = '0;
        tick(1);
        bus.H_count = 17'd1;
        tick(1);
    endtask

    task automatic hit_fatal(input logic [15:0] sc);
        int c;
        c = cyc;
        expect_at("fatal",      c + 1, S_OVER, 3'd0, sc);
        expect_at("fatal.hold", c + 2, S_OVER, 3'd0, sc);
        bus.atk_over = 5'b10000; bus.H_count = 17'd0; bus.V_count = 17'd0;
        tick(1);
        bus.atk_over = '0; bus.H_count = 17'd1;
        tick(2);
    endtask

    initial begin
        int c;
        clear = 1'b0;
        bus.start_btn = 1'b1;
        bus.H_count = 17'd1; bus.V_count = 17'd1;
        bus.atk_over = '0;
        tick(1);

        // Reset with start held, then release: start fires once.
        for (int i = 0; i < 3; i++) begin
            expect_at("rst", cyc, S_IDLE, 3'd3, 16'd0);
            if (i < 2) tick(1);
        end
        c = cyc;
        clear = 1'b1;
        expect_at("rel.1", c + 1, S_IDLE, 3'd3, 16'd0);
        expect_at("rel.2", c + 2, S_IDLE, 3'd3, 16'd0);
        expect_at("rel.3", c + 3, S_PLAY, 3'd3, 16'd0);
        tick(1);
        bus.start_btn = 1'b0;
        tick(3);

        // Back to IDLE, then measure start latency.
        c = cyc;
        clear = 1'b0;
        expect_at("rst2", c + 1, S_IDLE, 3'd3, 16'd0);
        tick(1);
        clear = 1'b1;
        tick(2);
        start_seq("start", S_IDLE, 3'd3, 16'd0);

        // Scoring and saturation.
        play_frames(10, 3'd3, 16'd0);
        c = cyc;
        expect_at("sat.fffe", c + 65524, S_PLAY, 3'd3, 16'hFFFE);
        expect_at("sat.ffff", c + 65525, S_PLAY, 3'd3, 16'hFFFF);
        expect_at("sat.hold", c + 65527, S_PLAY, 3'd3, 16'hFFFF);
        bus.H_count = 17'd0; bus.V_count = 17'd0;
        tick(65527);
        bus.H_count = 17'd1;
        tick(1);

        // Hits down to game over, then restart.
        hit_nf(5'b00110, 3'd2, 16'hFFFF);
        hit_nf(5'b01000, 3'd1, 16'hFFFF);
        hit_fatal(16'hFFFF);
        start_seq("restart", S_OVER, 3'd0, 16'hFFFF);

        // Fatal hit coinciding with frame_tick leaves score unchanged.
        play_frames(2, 3'd3, 16'd0);
        hit_nf(5'b11111, 3'd2, 16'd2);
        hit_nf(5'b00001, 3'd1, 16'd2);
        hit_fatal(16'd2);
        start_seq("restart2", S_OVER, 3'd0, 16'd2);

        // Reset in the middle of a hit hold.
        play_frames(3, 3'd3, 16'd0);
        c = cyc;
        expect_at("mid.hit", c + 1,  S_HIT,  3'd2, 16'd3);
        expect_at("mid.30",  c + 31, S_HIT,  3'd2, 16'd3);
        expect_at("mid.rst", c + 32, S_IDLE, 3'd3, 16'd0);
        expect_at("mid.idl", c + 34, S_IDLE, 3'd3, 16'd0);
        bus.atk_over = 5'b00001;
        tick(1);
        bus.atk_over = '0; bus.H_count = 17'd0; bus.V_count = 17'd0;
        tick(30);
        clear = 1'b0;
        tick(1);
        clear = 1'b1; bus.H_count = 17'd1;
        tick(3);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
